// File: rtl/pa_riscv.sv
// Shared RISC-V encodings for the single-cycle and multicycle cores.
// Holds opcode, ALU-op and datapath-select encodings plus the multicycle
// controller's state type and per-state control word.
package pa_riscv;

   // Major opcodes understood by the cores (instruction bits [6:0]).
   typedef enum logic [6:0] {
      LW         = 7'b0000011,
      I_TYPE_ALU = 7'b0010011,
      SW         = 7'b0100011,
      R_TYPE_ALU = 7'b0110011,
      B_TYPE     = 7'b1100011,
      JAL        = 7'b1101111
   } ty_OPCODE;

   // ALU operation; the encoding is {funct7b5, funct3} of the matching R-type op.
   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b1000,
      ALU_XOR = 4'b0100,
      ALU_OR  = 4'b0110,
      ALU_AND = 4'b0111
   } ty_ALU_OP;

   // Register-file write-data source for the single-cycle core.
   typedef enum logic [1:0] {
      WD_ALU_RESULT = 2'b00,
      WD_READ_DATA  = 2'b01,
      WD_PC_PLUS_4  = 2'b10
   } ty_INPUT_TO_WRITEDATA;

   // Multicycle controller states.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } ty_STATE;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } ty_ALU_SRC_A;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } ty_ALU_SRC_B;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } ty_IMM_SRC;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } ty_RESULT_SRC;

   localparam logic [2:0] F3_BEQ = 3'b000;

   // Moore part of the control word for one state. pc_write_zero marks the
   // state where the PC load is qualified by the ALU zero flag; alu_funct
   // selects the funct-decoded ALU op instead of the fixed alu_op.
   typedef struct packed {
      logic         pc_write;
      logic         pc_write_zero;
      logic         adr_src;
      logic         mem_write;
      logic         ir_write;
      ty_RESULT_SRC result_src;
      ty_ALU_SRC_A  src_a;
      ty_ALU_SRC_B  src_b;
      logic         reg_write;
      ty_ALU_OP     alu_op;
      logic         alu_funct;
   } ty_CTRL;

   // Control word for a state; anything not set here stays zero.
   function automatic ty_CTRL f_state_ctrl(input ty_STATE st);
      ty_CTRL c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_write   = 1'b1;
            c.src_a      = SRCA_PC;
            c.src_b      = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
            c.alu_op     = ALU_ADD;
         end
         S_DECODE: begin
            // Precompute branch/jump target OldPC + imm into ALUOut.
            c.src_a  = SRCA_OLDPC;
            c.src_b  = SRCB_IMM;
            c.alu_op = ALU_ADD;
         end
         S_MEMADR: begin
            c.src_a  = SRCA_RS1;
            c.src_b  = SRCB_IMM;
            c.alu_op = ALU_ADD;
         end
         S_MEMREAD: begin
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
            c.mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            c.src_a     = SRCA_RS1;
            c.src_b     = SRCB_RS2;
            c.alu_funct = 1'b1;
         end
         S_EXECUTEI: begin
            c.src_a     = SRCA_RS1;
            c.src_b     = SRCB_IMM;
            c.alu_funct = 1'b1;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_BEQ: begin
            // ALUOut still holds the target computed in DECODE.
            c.src_a         = SRCA_RS1;
            c.src_b         = SRCB_RS2;
            c.result_src    = RES_ALUOUT;
            c.alu_op        = ALU_SUB;
            c.pc_write_zero = 1'b1;
         end
         S_JAL: begin
            // PC <- target from DECODE while ALU forms the link value OldPC + 4.
            c.src_a      = SRCA_OLDPC;
            c.src_b      = SRCB_FOUR;
            c.result_src = RES_ALUOUT;
            c.pc_write   = 1'b1;
            c.alu_op     = ALU_ADD;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Immediate format implied by the opcode.
   function automatic ty_IMM_SRC f_imm_src(input logic [6:0] op);
      ty_IMM_SRC imm;
      case (op)
         LW, I_TYPE_ALU: imm = IMM_I;
         SW:             imm = IMM_S;
         B_TYPE:         imm = IMM_B;
         JAL:            imm = IMM_J;
         default:        imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational funct-field to ALU-op decode for the multicycle controller.
// I-type instructions ignore funct7b5 so that SUB is reachable only from
// R-type; any combination outside ADD/SUB/AND/OR/XOR is flagged illegal.
module mc_alu_decoder
   import pa_riscv::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_rtype,
   output ty_ALU_OP   o_alu_op,
   output logic       o_illegal
);

   logic [3:0] key;

   assign key = {i_funct7b5 & i_rtype, i_funct3};

   // Map the funct key onto the ALU op; unknown keys default to ADD and flag illegal.
   always_comb begin
      o_alu_op  = ALU_ADD;
      o_illegal = 1'b0;
      case (key)
         4'b0000: o_alu_op  = ALU_ADD;
         4'b1000: o_alu_op  = ALU_SUB;
         4'b0100: o_alu_op  = ALU_XOR;
         4'b0110: o_alu_op  = ALU_OR;
         4'b0111: o_alu_op  = ALU_AND;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | read instruction at PC, latch IR/OldPC, PC <- PC + 4
//   DECODE   | read registers, ALUOut <- OldPC + imm, classify opcode
//   MEMADR   | ALUOut <- rs1 + imm (load/store address)
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | rd <- memory data
//   MEMWRITE | write rs2 to data memory at ALUOut
//   EXECUTER | ALUOut <- rs1 op rs2
//   EXECUTEI | ALUOut <- rs1 op imm
//   ALUWB    | rd <- ALUOut
//   BEQ      | compare rs1/rs2, PC <- ALUOut when equal
//   JAL      | PC <- ALUOut, ALUOut <- OldPC + 4 for the link
//
// The Moore control word is registered alongside the state (computed from the
// next state), so outputs come straight from flops. The only inputs reaching
// the outputs combinationally are the IR-derived decodes and the zero flag
// used in BEQ. Reset clears the write enables immediately rather than waiting
// for a clock.
module mc_controller
   import pa_riscv::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_zero,
   output logic       o_pcWrite,
   output logic       o_adrSrc,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic [1:0] o_resultSrc,
   output logic [1:0] o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_immSrc,
   output logic       o_regWrite,
   output logic [3:0] o_aluControl,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   ty_STATE   state_q;
   ty_STATE   state_d;
   ty_CTRL    ctrl_q;
   logic      illegal_d;
   logic      is_rtype;
   logic      dec_illegal;
   ty_ALU_OP  dec_alu_op;
   ty_IMM_SRC imm_src;
   logic      run;

   assign is_rtype = (i_op == R_TYPE_ALU);
   assign run      = ~i_rst;

   mc_alu_decoder u_alu_dec (
      .i_funct3   (i_funct3),
      .i_funct7b5 (i_funct7b5),
      .i_rtype    (is_rtype),
      .o_alu_op   (dec_alu_op),
      .o_illegal  (dec_illegal)
   );

   // Next-state selection and the DECODE-cycle illegal-instruction flag.
   always_comb begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (i_op)
               LW, SW: state_d = S_MEMADR;
               R_TYPE_ALU: begin
                  if (dec_illegal) illegal_d = 1'b1;
                  else             state_d   = S_EXECUTER;
               end
               I_TYPE_ALU: begin
                  if (dec_illegal) illegal_d = 1'b1;
                  else             state_d   = S_EXECUTEI;
               end
               B_TYPE: begin
                  if (i_funct3 == F3_BEQ) state_d   = S_BEQ;
                  else                    illegal_d = 1'b1;
               end
               JAL:     state_d   = S_JAL;
               default: illegal_d = 1'b1;
            endcase
         end
         S_MEMADR:   state_d = (i_op == SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // State register with the matching control word registered alongside it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= f_state_ctrl(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= f_state_ctrl(state_d);
      end
   end

   // Immediate format follows the IR opcode in every state.
   always_comb begin
      imm_src = f_imm_src(i_op);
   end

   // While reset is held the registered word already shows FETCH; the write
   // enables are masked so nothing architectural changes until release.
   assign o_pcWrite    = run & (ctrl_q.pc_write | (ctrl_q.pc_write_zero & i_zero));
   assign o_irWrite    = run & ctrl_q.ir_write;
   assign o_memWrite   = run & ctrl_q.mem_write;
   assign o_regWrite   = run & ctrl_q.reg_write;
   assign o_illegal    = run & illegal_d;
   assign o_adrSrc     = ctrl_q.adr_src;
   assign o_resultSrc  = ctrl_q.result_src;
   assign o_aluSrcA    = ctrl_q.src_a;
   assign o_aluSrcB    = ctrl_q.src_b;
   assign o_aluControl = ctrl_q.alu_funct ? dec_alu_op : ctrl_q.alu_op;
   assign o_immSrc     = imm_src;
   assign o_state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for the multicycle controller: each instruction is walked
// cycle by cycle against hand-written control words.
module tb_mc_controller;

   logic       i_clk;
   logic       i_rst;
   logic [6:0] i_op;
   logic [2:0] i_funct3;
   logic       i_funct7b5;
   logic       i_zero;
   logic       o_pcWrite;
   logic       o_adrSrc;
   logic       o_memWrite;
   logic       o_irWrite;
   logic [1:0] o_resultSrc;
   logic [1:0] o_aluSrcA;
   logic [1:0] o_aluSrcB;
   logic [1:0] o_immSrc;
   logic       o_regWrite;
   logic [3:0] o_aluControl;
   logic       o_illegal;
   logic [3:0] o_state;

   int n_tot;
   int n_bad;

   logic [21:0] obs_w;
   logic [21:0] exp_q [5];

   mc_controller dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_op         (i_op),
      .i_funct3     (i_funct3),
      .i_funct7b5   (i_funct7b5),
      .i_zero       (i_zero),
      .o_pcWrite    (o_pcWrite),
      .o_adrSrc     (o_adrSrc),
      .o_memWrite   (o_memWrite),
      .o_irWrite    (o_irWrite),
      .o_resultSrc  (o_resultSrc),
      .o_aluSrcA    (o_aluSrcA),
      .o_aluSrcB    (o_aluSrcB),
      .o_immSrc     (o_immSrc),
      .o_regWrite   (o_regWrite),
      .o_aluControl (o_aluControl),
      .o_illegal    (o_illegal),
      .o_state      (o_state)
   );

   always #5 i_clk = ~i_clk;

   assign obs_w = {o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
                   o_aluSrcA, o_aluSrcB, o_immSrc, o_regWrite, o_aluControl,
                   o_illegal, o_state};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Packs one expected control word in the same field order as obs_w.
   function automatic logic [21:0] w(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] imm, input logic rw,
                                     input logic [3:0] alu, input logic ill,
                                     input logic [3:0] st);
      return {pcw, adr, mw, irw, res, a, b, imm, rw, alu, ill, st};
   endfunction

   function automatic logic [21:0] e_fetch(input logic [1:0] imm);
      return w(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, imm, 1'b0, 4'b0000, 1'b0, 4'd0);
   endfunction
   function automatic logic [21:0] e_decode(input logic [1:0] imm, input logic ill);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0, 4'b0000, ill, 4'd1);
   endfunction
   function automatic logic [21:0] e_memadr(input logic [1:0] imm);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, 4'b0000, 1'b0, 4'd2);
   endfunction
   function automatic logic [21:0] e_memread(input logic [1:0] imm);
      return w(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 4'b0000, 1'b0, 4'd3);
   endfunction
   function automatic logic [21:0] e_memwb(input logic [1:0] imm);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, imm, 1'b1, 4'b0000, 1'b0, 4'd4);
   endfunction
   function automatic logic [21:0] e_memwrite(input logic [1:0] imm);
      return w(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 4'b0000, 1'b0, 4'd5);
   endfunction
   function automatic logic [21:0] e_exer(input logic [1:0] imm, input logic [3:0] alu);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0, alu, 1'b0, 4'd6);
   endfunction
   function automatic logic [21:0] e_exei(input logic [1:0] imm, input logic [3:0] alu);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, alu, 1'b0, 4'd7);
   endfunction
   function automatic logic [21:0] e_aluwb(input logic [1:0] imm);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b1, 4'b0000, 1'b0, 4'd8);
   endfunction
   function automatic logic [21:0] e_beq(input logic [1:0] imm, input logic z);
      return w(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0, 4'b1000, 1'b0, 4'd9);
   endfunction
   function automatic logic [21:0] e_jal(input logic [1:0] imm);
      return w(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 1'b0, 4'b0000, 1'b0, 4'd10);
   endfunction
   function automatic logic [21:0] e_reset(input logic [1:0] imm);
      return w(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 1'b0, 4'b0000, 1'b0, 4'd0);
   endfunction

   task automatic set_exp(input logic [21:0] e0, input logic [21:0] e1, input logic [21:0] e2,
                          input logic [21:0] e3, input logic [21:0] e4);
      exp_q[0] = e0;
      exp_q[1] = e1;
      exp_q[2] = e2;
      exp_q[3] = e3;
      exp_q[4] = e4;
   endtask

   // Entered in FETCH just after a rising edge; leaves in the following FETCH.
   task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, input int n);
      i_op       = op;
      i_funct3   = f3;
      i_funct7b5 = f7;
      i_zero     = z;
      #1;
      for (int c = 0; c < n; c++) begin
         if (c != 0) begin
            @(posedge i_clk);
            #1;
         end
         chk($sformatf("%s_c%0d", tag, c), {10'd0, obs_w}, {10'd0, exp_q[c]});
      end
      @(posedge i_clk);
      #1;
      chk($sformatf("%s_back_to_fetch", tag), {28'd0, o_state}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tot      = 0;
      n_bad      = 0;
      i_clk      = 1'b0;
      i_rst      = 1'b0;
      i_op       = 7'd0;
      i_funct3   = 3'd0;
      i_funct7b5 = 1'b0;
      i_zero     = 1'b0;
      #1 i_rst = 1'b1;
      #1;
      chk("reset_async", {10'd0, obs_w}, {10'd0, e_reset(2'b00)});
      @(posedge i_clk);
      #1;
      chk("reset_held", {10'd0, obs_w}, {10'd0, e_reset(2'b00)});
      @(negedge i_clk);
      i_rst = 1'b0;

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_memadr(2'b00), e_memread(2'b00), e_memwb(2'b00));
      run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 5);

      set_exp(e_fetch(2'b01), e_decode(2'b01, 1'b0), e_memadr(2'b01), e_memwrite(2'b01), 22'd0);
      run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exer(2'b00, 4'b1000), e_aluwb(2'b00), 22'd0);
      run_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exer(2'b00, 4'b0000), e_aluwb(2'b00), 22'd0);
      run_instr("r_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exer(2'b00, 4'b0111), e_aluwb(2'b00), 22'd0);
      run_instr("r_and", 7'b0110011, 3'b111, 1'b0, 1'b1, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exer(2'b00, 4'b0110), e_aluwb(2'b00), 22'd0);
      run_instr("r_or", 7'b0110011, 3'b110, 1'b0, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exer(2'b00, 4'b0100), e_aluwb(2'b00), 22'd0);
      run_instr("r_xor", 7'b0110011, 3'b100, 1'b0, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exei(2'b00, 4'b0000), e_aluwb(2'b00), 22'd0);
      run_instr("i_add_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exei(2'b00, 4'b0110), e_aluwb(2'b00), 22'd0);
      run_instr("i_or", 7'b0010011, 3'b110, 1'b0, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b0), e_exei(2'b00, 4'b0100), e_aluwb(2'b00), 22'd0);
      run_instr("i_xor_f7", 7'b0010011, 3'b100, 1'b1, 1'b0, 4);

      set_exp(e_fetch(2'b10), e_decode(2'b10, 1'b0), e_beq(2'b10, 1'b1), 22'd0, 22'd0);
      run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 3);

      set_exp(e_fetch(2'b10), e_decode(2'b10, 1'b0), e_beq(2'b10, 1'b0), 22'd0, 22'd0);
      run_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, 3);

      set_exp(e_fetch(2'b11), e_decode(2'b11, 1'b0), e_jal(2'b11), e_aluwb(2'b11), 22'd0);
      run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 4);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b1), 22'd0, 22'd0, 22'd0);
      run_instr("ill_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 2);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b1), 22'd0, 22'd0, 22'd0);
      run_instr("ill_r_sll", 7'b0110011, 3'b001, 1'b0, 1'b0, 2);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b1), 22'd0, 22'd0, 22'd0);
      run_instr("ill_r_f7and", 7'b0110011, 3'b111, 1'b1, 1'b0, 2);

      set_exp(e_fetch(2'b00), e_decode(2'b00, 1'b1), 22'd0, 22'd0, 22'd0);
      run_instr("ill_i_slli", 7'b0010011, 3'b001, 1'b0, 1'b0, 2);

      set_exp(e_fetch(2'b10), e_decode(2'b10, 1'b1), 22'd0, 22'd0, 22'd0);
      run_instr("ill_bne", 7'b1100011, 3'b001, 1'b0, 1'b1, 2);

      // Reset in the middle of a store: memWrite must drop without a clock edge.
      i_op       = 7'b0100011;
      i_funct3   = 3'b010;
      i_funct7b5 = 1'b0;
      i_zero     = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk);
         #1;
      end
      chk("mid_sw_memwrite", {10'd0, obs_w}, {10'd0, e_memwrite(2'b01)});
      #1 i_rst = 1'b1;
      #1;
      chk("mid_sw_rst_memwrite", {31'd0, o_memWrite}, 32'd0);
      chk("mid_sw_rst_word", {10'd0, obs_w}, {10'd0, e_reset(2'b01)});
      @(posedge i_clk);
      #1;
      chk("mid_sw_rst_held_state", {28'd0, o_state}, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      set_exp(e_fetch(2'b11), e_decode(2'b11, 1'b0), e_jal(2'b11), e_aluwb(2'b11), 22'd0);
      run_instr("post_rst_jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 4);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters SHALL be none; all encodings SHALL come from pa_riscv.
REQ-002 i_clk  input  1  sole clock; every flop updates on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_op  input  7  opcode bits [6:0] from the instruction register.
REQ-005 i_funct3  input  3  instruction bits [14:12].
REQ-006 i_funct7b5  input  1  instruction bit 30.
REQ-007 i_zero  input  1  ALU zero flag, same cycle.
REQ-008 o_pcWrite  output  1  PC register load enable.
REQ-009 o_adrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 o_memWrite  output  1  data memory write strobe.
REQ-011 o_irWrite  output  1  instruction register and OldPC load enable.
REQ-012 o_resultSrc  output  2  Result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 o_aluSrcA  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 o_aluSrcB  output  2  SrcB select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-015 o_immSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 o_regWrite  output  1  register file write enable.
REQ-017 o_aluControl  output  4  ALU operation, ty_ALU_OP encoding.
REQ-018 o_illegal  output  1  one-cycle pulse on an unsupported instruction.
REQ-019 o_state  output  4  current state, for debug and bench visibility.

Function
REQ-020 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL; there SHALL be no stall input.
REQ-021 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (LW, SW), EXECUTER (R_TYPE_ALU), EXECUTEI (I_TYPE_ALU), BEQ (B_TYPE with funct3 000), JAL (JAL), otherwise FETCH.
REQ-022 MEMADR SHALL go to MEMREAD (LW) or MEMWRITE (SW); MEMREAD->MEMWB; EXECUTER and EXECUTEI SHALL go to ALUWB; JAL->ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ SHALL go to FETCH.
REQ-023 Unlisted outputs SHALL be 0 in every state.
REQ-024 FETCH SHALL drive irWrite=1, pcWrite=1, adrSrc=0, srcA=00, srcB=10, resultSrc=10, ALU ADD.
REQ-025 DECODE SHALL drive srcA=01, srcB=01, ALU ADD (branch/jump target precompute).
REQ-026 MEMADR SHALL drive srcA=10, srcB=01, ALU ADD.
REQ-027 MEMREAD SHALL drive adrSrc=1, resultSrc=00.
REQ-028 MEMWB SHALL drive resultSrc=01, regWrite=1.
REQ-029 MEMWRITE SHALL drive adrSrc=1, resultSrc=00, memWrite=1.
REQ-030 EXECUTER SHALL drive srcA=10, srcB=00, funct-decoded ALU op.
REQ-031 EXECUTEI SHALL drive srcA=10, srcB=01, funct-decoded ALU op.
REQ-032 ALUWB SHALL drive resultSrc=00, regWrite=1.
REQ-033 BEQ SHALL drive srcA=10, srcB=00, resultSrc=00, ALU SUB, and pcWrite = i_zero (the only Mealy output).
REQ-034 JAL SHALL drive srcA=01, srcB=10, resultSrc=00, pcWrite=1, ALU ADD.
REQ-035 The funct decode SHALL be {funct7b5,funct3} for R-type, with bit 3 forced 0 for I-type (SUB only on R-type); any decode outside ADD/SUB/AND/OR/XOR SHALL be illegal.
REQ-036 o_immSrc SHALL decode combinationally from i_op in every state: LW/I-type 00, SW 01, B_TYPE 10, JAL 11, else 00.
REQ-037 o_illegal SHALL pulse for the DECODE cycle of an unsupported opcode, funct combination or branch funct3; the FSM SHALL then return to FETCH with no architectural write.

Reset
REQ-038 Asserting i_rst SHALL force the state to FETCH asynchronously.
REQ-039 While i_rst is high, pcWrite, irWrite, memWrite, regWrite and illegal SHALL be 0; the other outputs SHALL take their FETCH values.
REQ-040 Reset mid-instruction SHALL abandon it; the first FETCH after release SHALL be a normal FETCH.

Structure
REQ-041 ty_STATE, ty_ALU_SRC_A, ty_ALU_SRC_B, ty_IMM_SRC and ty_RESULT_SRC SHALL be added to pa_riscv; ty_INPUT_TO_WRITEDATA SHALL remain unchanged for the single-cycle core.
REQ-042 One sub-module, mc_alu_decoder, SHALL hold the combinational funct-to-ty_ALU_OP decode and its illegal flag.

Verification
REQ-043 LW (i_op 0000011): FETCH,DECODE,MEMADR,MEMREAD,MEMWB then FETCH; regWrite=1 and resultSrc=01 only in MEMWB.
REQ-044 SW: 4 cycles; memWrite=1 and adrSrc=1 only in MEMWRITE; immSrc=01 throughout.
REQ-045 R-type funct7b5=1, funct3=000 -> aluControl 1000 in EXECUTER; I-type funct7b5=1, funct3=000 -> 0000 in EXECUTEI.
REQ-046 BEQ: i_zero=1 -> pcWrite=1 in BEQ; i_zero=0 -> pcWrite=0; 3 cycles either way.
REQ-047 i_op 1111111 -> illegal=1 for the DECODE cycle only, next state FETCH, no write enables asserted.
REQ-048 i_rst asserted mid-MEMWRITE -> memWrite falls with no clock edge; o_state = FETCH.
